// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I multicycle sequencer and decoder.
// Holds the FSM state encoding, trap causes, writeback selects and timeout default.
package rv32i_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } trap_cause_e;

    localparam logic [1:0] RES_WB = 2'd0;
    localparam logic [1:0] MEM_WB = 2'd1;
    localparam logic [1:0] PC_WB  = 2'd2;

    localparam int TIMEOUT_CYCLES_DEF = 16;
    localparam int WAIT_W             = 4;

    function automatic logic is_req_state(input seq_state_e s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

    // Loads need the data port as well as stores.
    function automatic logic needs_mem(input logic mem_wen, input logic [1:0] wb_sel);
        return mem_wen || (wb_sel == MEM_WB);
    endfunction

    function automatic logic wb_sel_valid(input logic [1:0] wb_sel);
        return (wb_sel == RES_WB) || (wb_sel == MEM_WB) || (wb_sel == PC_WB);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-request cycles without a ready response.
// expired flags the last allowed wait cycle so the sequencer can trap on it.
module mem_wait_timer
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (count) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign expired = count && (wait_cnt == LAST_WAIT);

endmodule

// File: rtl/multicycle_seq.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with trap handling.
// Strobes are decoded from the current state; state, cause and instret are registered.
module multicycle_seq
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        mem_ready,
    input  logic        illegal_op,
    input  logic        reg_wen_i,
    input  logic        mem_wen_i,
    input  logic [1:0]  wb_sel_i,
    input  logic        trap_clr,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_dsel,
    output logic        ir_wen,
    output logic        pc_wen,
    output logic        rf_wen,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] instret,
    output logic [2:0]  state_o
);

    seq_state_e  state;
    trap_cause_e cause_q;
    logic        req_state;
    logic        timer_expired;

    assign req_state = is_req_state(state);

    // Held clear outside request states, so every FETCH/MEM entry starts from zero.
    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!req_state),
        .count   (req_state && !mem_ready),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cause_q <= CAUSE_NONE;
            instret <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (run) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        state <= ST_DECODE;
                    end else if (timer_expired) begin
                        state   <= ST_TRAP;
                        cause_q <= CAUSE_TIMEOUT;
                    end
                end
                ST_DECODE: begin
                    if (illegal_op) begin
                        state   <= ST_TRAP;
                        cause_q <= CAUSE_ILLEGAL;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= needs_mem(mem_wen_i, wb_sel_i) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        state <= ST_WB;
                    end else if (timer_expired) begin
                        state   <= ST_TRAP;
                        cause_q <= CAUSE_TIMEOUT;
                    end
                end
                // run is sampled only here, so a mid-instruction drop still retires.
                ST_WB: begin
                    instret <= instret + 32'd1;
                    state   <= run ? ST_FETCH : ST_IDLE;
                end
                ST_TRAP: begin
                    if (trap_clr) begin
                        state   <= ST_IDLE;
                        cause_q <= CAUSE_NONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_dsel = 1'b0;
        ir_wen   = 1'b0;
        pc_wen   = 1'b0;
        rf_wen   = 1'b0;
        trap     = 1'b0;
        unique case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_wen  = mem_ready;
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                mem_dsel = 1'b1;
                mem_we   = mem_wen_i;
            end
            ST_WB: begin
                pc_wen = 1'b1;
                rf_wen = reg_wen_i;
            end
            ST_TRAP: begin
                trap = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign trap_cause = cause_q;
    assign state_o    = state;

endmodule

// File: doc/multicycle_seq.md
MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, the number of consecutive memory-request cycles without mem_ready before a bus-error trap.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 run  input  1  1 = execute instructions; 0 = stop at the next instruction boundary.
REQ-005 mem_ready  input  1  memory accepted/completed the current request.
REQ-006 illegal_op, reg_wen_i, mem_wen_i  input  1 each  decoded controls for the current instruction.
REQ-007 wb_sel_i  input  2  decoded writeback select; 1 = MEM_WB (load).
REQ-008 trap_clr  input  1  acknowledges and clears a pending trap.
REQ-009 mem_req, mem_we, mem_dsel  output  1 each  memory request, write enable, port select (0 = instruction, 1 = data).
REQ-010 ir_wen, pc_wen, rf_wen  output  1 each  instruction-register, PC and register-file write strobes.
REQ-011 trap  output  1  trap pending.
REQ-012 trap_cause  output  2  0 = none, 1 = illegal opcode, 2 = bus timeout.
REQ-013 instret  output  32  count of retired instructions.
REQ-014 state_o  output  3  current FSM state encoding, for debug.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-016 IDLE SHALL drive all strobes to 0 and SHALL move to FETCH when run=1.
REQ-017 FETCH SHALL assert mem_req=1, mem_dsel=0 and mem_we=0.
REQ-018 In FETCH, when mem_ready=1, ir_wen SHALL pulse for that cycle and the FSM SHALL move to DECODE.
REQ-019 DECODE SHALL last one cycle: illegal_op=1 -> TRAP with cause 1; otherwise -> EXEC.
REQ-020 EXEC SHALL last one cycle: mem_wen_i=1 or wb_sel_i=1 -> MEM; otherwise -> WB.
REQ-021 MEM SHALL assert mem_req=1, mem_dsel=1 and mem_we=mem_wen_i, and SHALL move to WB on mem_ready=1.
REQ-022 WB SHALL last one cycle with pc_wen=1, rf_wen=reg_wen_i and instret incremented by 1.
REQ-023 WB SHALL move to FETCH when run=1, otherwise to IDLE.
REQ-024 A 4-bit wait counter SHALL clear on entry to FETCH or MEM and SHALL increment on each request cycle without mem_ready.
REQ-025 When the wait counter equals TIMEOUT_CYCLES-1 and mem_ready=0, the FSM SHALL move to TRAP with cause 2.
REQ-026 mem_ready SHALL take priority over timeout in the same cycle.
REQ-027 mem_ready present in the first request cycle SHALL complete the access in that cycle (zero wait).
REQ-028 mem_ready outside FETCH and MEM SHALL be ignored.
REQ-029 TRAP SHALL hold trap=1, the latched trap_cause and all strobes 0; trap_clr=1 SHALL move to IDLE and clear trap_cause to 0.
REQ-030 trap_clr outside TRAP SHALL be ignored.
REQ-031 run falling mid-instruction SHALL NOT abort the instruction; it SHALL complete through WB and then go to IDLE.
REQ-032 instret SHALL wrap from 0xFFFFFFFF to 0 and SHALL NOT increment on trapped instructions.
REQ-033 All outputs except instret, trap_cause and state_o SHALL be decoded combinationally from the current state and inputs only.

Reset
REQ-034 rst_n=0 SHALL asynchronously force state IDLE, wait counter 0, instret 0 and trap_cause 0, and all strobes, trap and mem_req SHALL read 0.
REQ-035 Reset mid-access SHALL drop mem_req immediately, with no retirement.

Structure
REQ-036 The state enum, the trap-cause enum, the WB code constants (RES_WB/MEM_WB/PC_WB) and the TIMEOUT_CYCLES default SHALL reside in the shared package rv32i_pkg, also used by the decoder.
REQ-037 The wait counter SHALL be a sub-module mem_wait_timer (clear, count, expired outputs); the FSM and instret SHALL stay in multicycle_seq.

Verification
REQ-038 ALU op: run=1, zero-wait memory, reg_wen_i=1, mem_wen_i=0, wb_sel_i=0 -> FETCH,DECODE,EXEC,WB in 4 cycles, rf_wen=1 in WB, instret=1.
REQ-039 Load with 3 wait states per access: wb_sel_i=1 -> FETCH 4 cycles, MEM 4 cycles with mem_dsel=1 and mem_we=0, 11 cycles total, rf_wen=1.
REQ-040 Store: mem_wen_i=1, reg_wen_i=0 -> MEM has mem_we=1, WB has rf_wen=0 and pc_wen=1.
REQ-041 Illegal: illegal_op=1 in DECODE -> trap=1, trap_cause=1, instret unchanged; trap_clr -> IDLE, trap_cause=0.
REQ-042 Timeout: mem_ready stuck 0 -> TRAP with cause 2 after exactly 16 FETCH cycles; mem_ready=1 on the 16th cycle instead -> DECODE, no trap.
REQ-043 Boundaries: instret preloaded to 0xFFFFFFFF -> 0 after one retirement; run=0 asserted in EXEC -> WB then IDLE; rst_n low during MEM -> mem_req=0 the same cycle.
